// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl
//   Stall and bubble generator for the 5-stage pipeline. It detects the
//   hazards the bypass network cannot resolve:
//   - load-use
//   - a branch in ID whose operands come from a load
//   - HI/LO access while the multi-cycle mul/div unit is busy
//   While any of these is present it holds the front end until the operand
//   exists.
//
// Parameters
//   MUL_LAT  cycles from mult/multu start in EX until HI/LO valid (2..15)
//   DIV_LAT  cycles from div/divu start in EX until HI/LO valid (2..15)
//
// Ports
//   clock, reset                   clock, synchronous active-high reset
//   ID_rs, ID_rt                   source register fields of the ID instruction
//   ID_UseRs, ID_UseRt             ID instruction actually reads rs / rt
//   ID_Branch                      ID instruction needs its operands in ID
//   ID_HiLoAcc                     ID instruction touches HI/LO
//   ID_EX_MemRead, ID_EX_waddr     load flag / destination of the EX instruction
//   EX_MEM_MemRead, EX_MEM_waddr   load flag / destination of the MEM instruction
//   EX_MulStart, EX_DivStart       one-cycle start pulses from EX
//   PCWrite, IF_ID_Write           0 = hold PC / IF_ID
//   ID_EX_Bubble                   1 = insert NOP into ID_EX
//   HiLoBusy                       multiply/divide result pending
//
// Optional feature (macro HAZARD_STALL_STATS_EN)
//   When the macro is defined, two extra 32-bit outputs are added:
//   StallCnt counts cycles with any stall, and HiLoStallCnt counts cycles
//   with a HI/LO stall. Both clear on reset and wrap around.
module hazard_stall_ctrl #(
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 12
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [4:0] ID_rs,
    input  logic [4:0] ID_rt,
    input  logic       ID_UseRs,
    input  logic       ID_UseRt,
    input  logic       ID_Branch,
    input  logic       ID_HiLoAcc,
    input  logic       ID_EX_MemRead,
    input  logic [4:0] ID_EX_waddr,
    input  logic       EX_MEM_MemRead,
    input  logic [4:0] EX_MEM_waddr,
    input  logic       EX_MulStart,
    input  logic       EX_DivStart,
    output logic       PCWrite,
    output logic       IF_ID_Write,
    output logic       ID_EX_Bubble,
    output logic       HiLoBusy
`ifdef HAZARD_STALL_STATS_EN
    ,
    output logic [31:0] StallCnt,
    output logic [31:0] HiLoStallCnt
`endif
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;

    localparam logic [3:0] MUL_LOAD = 4'(MUL_LAT - 1);
    localparam logic [3:0] DIV_LOAD = 4'(DIV_LAT - 1);

    logic [1:0] state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    logic ex_match, mem_match;
    logic stall_lu, stall_br, stall_hl, stall;

    // Hazard detection. A destination of $0 never creates a dependency.
    always_comb begin
        ex_match  = (ID_EX_waddr != 5'd0) &&
                    ((ID_UseRs && (ID_rs == ID_EX_waddr)) ||
                     (ID_UseRt && (ID_rt == ID_EX_waddr)));
        mem_match = (EX_MEM_waddr != 5'd0) &&
                    ((ID_UseRs && (ID_rs == EX_MEM_waddr)) ||
                     (ID_UseRt && (ID_rt == EX_MEM_waddr)));
        stall_lu  = ID_EX_MemRead && ex_match;
        stall_br  = ID_Branch && EX_MEM_MemRead && mem_match;
        // At cnt = 1 HI/LO is written at the end of this cycle and the
        // bypass delivers it, so only cnt > 1 has to hold the instruction.
        stall_hl  = ID_HiLoAcc && (state_q != S_IDLE) && (cnt_q > 4'd1);
        // Reset overrides every hazard so the front end keeps moving.
        stall     = !reset && (stall_lu || stall_br || stall_hl);
    end

    assign PCWrite      = ~stall;
    assign IF_ID_Write  = ~stall;
    assign ID_EX_Bubble = stall;
    assign HiLoBusy     = (state_q != S_IDLE);

    // Mul/div tracking. Start pulses while busy are ignored because the
    // HI/LO stall keeps a second mul/div from issuing; divide beats multiply.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == S_IDLE) begin
            if (EX_DivStart) begin
                state_d = S_DIV;
                cnt_d   = DIV_LOAD;
            end else if (EX_MulStart) begin
                state_d = S_MUL;
                cnt_d   = MUL_LOAD;
            end
        end else if (cnt_q <= 4'd1) begin
            state_d = S_IDLE;
            cnt_d   = 4'd0;
        end else begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef HAZARD_STALL_STATS_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] hl_cnt_q, hl_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q + {31'd0, stall};
        hl_cnt_d    = hl_cnt_q + {31'd0, stall_hl};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cnt_q <= 32'd0;
            hl_cnt_q    <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            hl_cnt_q    <= hl_cnt_d;
        end
    end

    assign StallCnt     = stall_cnt_q;
    assign HiLoStallCnt = hl_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Testbench for hazard_stall_ctrl: directed pipeline scenarios followed by
// randomized traffic, checked against a cycle-numbered reference model.
module tb_hazard_stall_ctrl;

    localparam int MUL_LAT = 4;
    localparam int DIV_LAT = 12;

    logic       clock = 1'b0;
    logic       reset;
    logic [4:0] ID_rs, ID_rt, ID_EX_waddr, EX_MEM_waddr;
    logic       ID_UseRs, ID_UseRt, ID_Branch, ID_HiLoAcc;
    logic       ID_EX_MemRead, EX_MEM_MemRead, EX_MulStart, EX_DivStart;
    logic       PCWrite, IF_ID_Write, ID_EX_Bubble, HiLoBusy;
`ifdef HAZARD_STALL_STATS_EN
    logic [31:0] StallCnt, HiLoStallCnt;
`endif

    hazard_stall_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clock(clock), .reset(reset),
        .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_UseRs(ID_UseRs), .ID_UseRt(ID_UseRt),
        .ID_Branch(ID_Branch), .ID_HiLoAcc(ID_HiLoAcc),
        .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_waddr(ID_EX_waddr),
        .EX_MEM_MemRead(EX_MEM_MemRead), .EX_MEM_waddr(EX_MEM_waddr),
        .EX_MulStart(EX_MulStart), .EX_DivStart(EX_DivStart),
        .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write),
        .ID_EX_Bubble(ID_EX_Bubble), .HiLoBusy(HiLoBusy)
`ifdef HAZARD_STALL_STATS_EN
        , .StallCnt(StallCnt), .HiLoStallCnt(HiLoStallCnt)
`endif
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    // Reference model: a multiply/divide started in cycle S with latency L
    // keeps HI/LO busy during cycles S+1 .. S+L-1 and blocks HI/LO access
    // during cycles S+1 .. S+L-2.
    int cyc       = 0;
    int start_cyc = -100;
    int ready_at  = -100;
    int m_stall_cnt = 0;
    int m_hl_cnt    = 0;

    function automatic bit m_busy();
        return (cyc > start_cyc) && (cyc < ready_at);
    endfunction

    function automatic bit m_hl();
        return !reset && ID_HiLoAcc && m_busy() && (cyc < ready_at - 1);
    endfunction

    function automatic bit reads(input logic [4:0] r);
        return (r != 5'd0) && ((ID_UseRs && ID_rs == r) || (ID_UseRt && ID_rt == r));
    endfunction

    function automatic bit m_stall();
        if (reset) return 1'b0;
        return (ID_EX_MemRead && reads(ID_EX_waddr)) ||
               (ID_Branch && EX_MEM_MemRead && reads(EX_MEM_waddr)) || m_hl();
    endfunction

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: check outputs at the falling edge, advance the model at the
    // rising edge, then leave 1 time unit before new inputs are driven.
    task automatic cycle(input string tag, input int exp_stall = -1, input int exp_busy = -1);
        bit s;
        @(negedge clock);
        s = m_stall();
        cmp({tag, "_pcwrite"}, {31'd0, PCWrite}, {31'd0, !s});
        cmp({tag, "_ifid"}, {31'd0, IF_ID_Write}, {31'd0, !s});
        cmp({tag, "_bubble"}, {31'd0, ID_EX_Bubble}, {31'd0, s});
        cmp({tag, "_busy"}, {31'd0, HiLoBusy}, {31'd0, m_busy()});
        if (exp_stall >= 0) cmp({tag, "_dir_stall"}, {31'd0, ID_EX_Bubble}, 32'(exp_stall));
        if (exp_busy >= 0) cmp({tag, "_dir_busy"}, {31'd0, HiLoBusy}, 32'(exp_busy));
`ifdef HAZARD_STALL_STATS_EN
        cmp({tag, "_stallcnt"}, StallCnt, 32'(m_stall_cnt));
        cmp({tag, "_hlcnt"}, HiLoStallCnt, 32'(m_hl_cnt));
`endif
        @(posedge clock);
        if (reset) begin
            start_cyc   = -100;
            ready_at    = -100;
            m_stall_cnt = 0;
            m_hl_cnt    = 0;
        end else begin
            if (s) m_stall_cnt++;
            if (m_hl()) m_hl_cnt++;
            if (!m_busy() && (EX_DivStart || EX_MulStart)) begin
                start_cyc = cyc;
                ready_at  = cyc + (EX_DivStart ? DIV_LAT : MUL_LAT);
            end
        end
        cyc++;
        #1;
    endtask

    task automatic idle_inputs();
        ID_rs = 0; ID_rt = 0; ID_UseRs = 0; ID_UseRt = 0; ID_Branch = 0;
        ID_HiLoAcc = 0; ID_EX_MemRead = 0; ID_EX_waddr = 0;
        EX_MEM_MemRead = 0; EX_MEM_waddr = 0; EX_MulStart = 0; EX_DivStart = 0;
    endtask

    initial begin
        idle_inputs();
        // Reset with a live load-use hazard on the inputs: stall must stay low.
        reset = 1;
        ID_EX_MemRead = 1; ID_EX_waddr = 5; ID_rs = 5; ID_UseRs = 1;
        cycle("rst0", 0);
        cycle("rst1", 0, 0);
        reset = 0;

        // lw $5 in EX, add reading $5 in ID: one stall, then released.
        cycle("lu_stall", 1);
        ID_EX_MemRead = 0; EX_MEM_MemRead = 1; EX_MEM_waddr = 5;
        cycle("lu_release", 0);

        // lw $0 in EX, ID reads $0: no hazard.
        idle_inputs();
        ID_EX_MemRead = 1; ID_UseRs = 1;
        cycle("lw_r0", 0);

        // lw $7 then beq reading $7: load-use stall, branch-load stall, release.
        idle_inputs();
        ID_Branch = 1; ID_UseRt = 1; ID_rt = 7;
        ID_EX_MemRead = 1; ID_EX_waddr = 7;
        cycle("br_lu", 1);
        ID_EX_MemRead = 0; ID_EX_waddr = 0; EX_MEM_MemRead = 1; EX_MEM_waddr = 7;
        cycle("br_mem", 1);
        EX_MEM_MemRead = 0; EX_MEM_waddr = 0;
        cycle("br_go", 0);

        // Divide with mflo behind it: 11 busy cycles, 10 stalls.
        idle_inputs();
        reset = 1;
        cycle("div_rst", 0);
        reset = 0;
        EX_DivStart = 1;
        cycle("div_start", 0, 0);
        EX_DivStart = 0; ID_HiLoAcc = 1;
        for (int i = 0; i < DIV_LAT - 2; i++) cycle("div_wait", 1, 1);
        cycle("div_last", 0, 1);
        ID_HiLoAcc = 0;
        cycle("div_done", 0, 0);
`ifdef HAZARD_STALL_STATS_EN
        cmp("div_stallcnt", StallCnt, 32'd10);
        cmp("div_hlstallcnt", HiLoStallCnt, 32'd10);
`endif

        // Multiply aborted by reset on its second busy cycle.
        EX_MulStart = 1;
        cycle("mul_start", 0, 0);
        EX_MulStart = 0; ID_HiLoAcc = 1;
        cycle("mul_busy1", 1, 1);
        reset = 1;
        cycle("mul_rst", 0, 1);
        reset = 0;
        cycle("mul_after", 0, 0);

        // Simultaneous starts: divide wins, so still busy past MUL_LAT.
        idle_inputs();
        EX_MulStart = 1; EX_DivStart = 1;
        cycle("both_start", 0, 0);
        idle_inputs();
        for (int i = 0; i < MUL_LAT + 1; i++) cycle("both_busy", 0, 1);
        for (int i = 0; i < DIV_LAT; i++) cycle("both_drain");

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            reset          = ($urandom_range(0, 59) == 0);
            ID_rs          = 5'($urandom_range(0, 3));
            ID_rt          = 5'($urandom_range(0, 3));
            ID_UseRs       = 1'($urandom);
            ID_UseRt       = 1'($urandom);
            ID_Branch      = 1'($urandom);
            ID_HiLoAcc     = 1'($urandom);
            ID_EX_MemRead  = 1'($urandom);
            ID_EX_waddr    = 5'($urandom_range(0, 3));
            EX_MEM_MemRead = 1'($urandom);
            EX_MEM_waddr   = 5'($urandom_range(0, 3));
            EX_MulStart    = ($urandom_range(0, 9) == 0);
            EX_DivStart    = ($urandom_range(0, 14) == 0);
            cycle("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
